// File: rtl/ifu_i_mem_fill_rsp.sv
// rtl/ifu_i_mem_fill_rsp.sv - instruction memory responder for I-cache line fills
//
// Purpose: holds the instruction memory, queues fill requests in an in-order
// FIFO and returns one 128-bit cache line per request after RSP_LATENCY cycles.
// Ports:
//   Clk, RstN    clock and synchronous active-low reset
//   FillReq      {fill_requested_address[31:0], fill_requested_address_valid}
//   FillRsp      {filled_instruction[127:0], valid, address[31:0]}
//   MemWrEn      program-load word write enable
//   MemWrAddr    program-load byte address (bits [1:0] ignored)
//   MemWrData    program-load write data
//   Busy         registered: FIFO non-empty or FSM not idle
//   ReqOverflow  sticky flag, a request was dropped on a full FIFO
module ifu_i_mem_fill_rsp #(
   parameter int I_MEM_WORDS    = 4096,
   parameter int RSP_LATENCY    = 4,
   parameter int REQ_FIFO_DEPTH = 4
) (
   input  logic         Clk,
   input  logic         RstN,
   input  logic [32:0]  FillReq,
   output logic [160:0] FillRsp,
   input  logic         MemWrEn,
   input  logic [31:0]  MemWrAddr,
   input  logic [31:0]  MemWrData,
   output logic         Busy,
   output logic         ReqOverflow
);

   localparam int WORD_W = $clog2(I_MEM_WORDS);
   localparam int LINE_W = WORD_W - 2;
   localparam int PTR_W  = $clog2(REQ_FIFO_DEPTH);
   // Pop cycle plus the RSP cycle account for two cycles; the read cycle
   // (counter == 0) for the third, so the counter covers the rest.
   localparam logic [3:0]     CNT_LOAD = 4'(RSP_LATENCY - 3);
   localparam logic [PTR_W:0] PTR_ONE  = (PTR_W + 1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RSP} state_t;

   state_t            state, state_next;
   logic [3:0]        cnt, cnt_next;
   logic              pop, line_load;

   logic [27:0]       fifo_mem [REQ_FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic              empty, full, push, overflow_set;

   logic [31:0]       mem [I_MEM_WORDS];
   logic [27:0]       cur_line;
   logic [LINE_W-1:0] line_idx;
   logic [127:0]      rsp_data;
   logic [31:0]       rsp_addr;
   logic              busy_q, busy_next, overflow_q;

   logic [31:0]       req_addr;
   logic              req_valid;
   logic              unused_bits;

   assign req_addr    = FillReq[32:1];
   assign req_valid   = FillReq[0];
   assign unused_bits = ^{FillReq, MemWrAddr};

   assign empty = (wr_ptr == rd_ptr);
   // Extra MSB on the pointers distinguishes full from empty.
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
   assign push         = req_valid && (!full || pop);
   assign overflow_set = req_valid && full && !pop;

   assign wr_ptr_next = push ? wr_ptr + PTR_ONE : wr_ptr;
   assign rd_ptr_next = pop  ? rd_ptr + PTR_ONE : rd_ptr;
   assign busy_next   = (wr_ptr_next != rd_ptr_next) || (state_next != S_IDLE);

   assign line_idx = cur_line[LINE_W-1:0];

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pop        = 1'b0;
      line_load  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               cnt_next   = CNT_LOAD;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               line_load  = 1'b1;
               state_next = S_RSP;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         S_RSP:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         state      <= S_IDLE;
         cnt        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cur_line   <= '0;
         rsp_data   <= '0;
         rsp_addr   <= '0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         busy_q <= busy_next;
         if (overflow_set) overflow_q <= 1'b1;
         if (pop) cur_line <= fifo_mem[rd_ptr[PTR_W-1:0]];
         if (line_load) begin
            rsp_data <= {mem[{line_idx, 2'd3}], mem[{line_idx, 2'd2}],
                         mem[{line_idx, 2'd1}], mem[{line_idx, 2'd0}]};
            rsp_addr <= {cur_line, 4'b0000};
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= req_addr[31:4];
   end

   // Non-blocking write: a line read in the same cycle sees the old word.
   always_ff @(posedge Clk) begin
      if (MemWrEn) mem[MemWrAddr[WORD_W+1:2]] <= MemWrData;
   end

   assign FillRsp     = {rsp_data, (state == S_RSP), rsp_addr};
   assign Busy        = busy_q;
   assign ReqOverflow = overflow_q;

endmodule
